// File: rtl/status_reporter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : status_reporter_pkg
// Description : Shared packet byte codes, duty words and helpers for the
//               status reporter and the command decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package status_reporter_pkg;

   // Framing bytes
   localparam logic [7:0] BYTE_START     = 8'h24;   // '$'
   localparam logic [7:0] BYTE_LF        = 8'h0A;

   // Direction codes
   localparam logic [7:0] DIR_FORWARD    = 8'h57;   // 'W'
   localparam logic [7:0] DIR_LEFT       = 8'h41;   // 'A'
   localparam logic [7:0] DIR_RIGHT      = 8'h44;   // 'D'
   localparam logic [7:0] DIR_STOP       = 8'h53;   // 'S'
   localparam logic [7:0] DIR_INVALID    = 8'h58;   // 'X'

   // Duty codes
   localparam logic [7:0] DUTY_CODE_HIGH = 8'h48;   // 'H'
   localparam logic [7:0] DUTY_CODE_LOW  = 8'h4C;   // 'L'
   localparam logic [7:0] DUTY_CODE_NEUT = 8'h4E;   // 'N'
   localparam logic [7:0] DUTY_CODE_ZERO = 8'h30;   // '0'
   localparam logic [7:0] DUTY_CODE_UNK  = 8'h3F;   // '?'

   // Duty words understood by the PWM stage
   localparam logic [31:0] DUTY_HIGH     = 32'd1288490188;
   localparam logic [31:0] DUTY_LOW      = 32'd2791728742;
   localparam logic [31:0] DUTY_NEUTRAL  = 32'd2147483648;

   localparam logic [2:0]  LAST_IDX      = 3'd6;    // packet is 7 bytes

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_WAIT_RDY  = 3'd2,
      ST_STROBE    = 3'd3,
      ST_WAIT_BUSY = 3'd4,
      ST_WAIT_DONE = 3'd5
   } state_t;

   // The three status characters carried by a packet
   typedef struct packed {
      logic [7:0] m;
      logic [7:0] d;
      logic [7:0] p;
   } status_t;

   // Uppercase ASCII hex digit for one nibble
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage : status_reporter_pkg
`default_nettype wire

// File: rtl/status_reporter_encode.sv
`default_nettype none
// ============================================================================
// Module      : status_encode
// Description : Combinational map of {mode, steering, duty} to the status
//               characters M, D, P and the two hex checksum characters.
// Revision    : 1.0 - initial release
// ============================================================================
module status_encode
   import status_reporter_pkg::*;
(
   input  logic [1:0]  mode,
   input  logic        stright,
   input  logic        left,
   input  logic        right,
   input  logic [31:0] duty,
   output status_t     status,
   output logic [7:0]  chk_hi,
   output logic [7:0]  chk_lo
);

   logic [7:0] w_chk;

   // Character encoding and XOR checksum of the three status characters
   always_comb begin
      status.m = 8'h30 + {6'd0, mode};

      case ({stright, left, right})
         3'b100:  status.d = DIR_FORWARD;
         3'b010:  status.d = DIR_LEFT;
         3'b001:  status.d = DIR_RIGHT;
         3'b000:  status.d = DIR_STOP;
         default: status.d = DIR_INVALID;
      endcase

      if (duty == DUTY_HIGH)
         status.p = DUTY_CODE_HIGH;
      else if (duty == DUTY_LOW)
         status.p = DUTY_CODE_LOW;
      else if (duty == DUTY_NEUTRAL)
         status.p = DUTY_CODE_NEUT;
      else if (duty == 32'd0)
         status.p = DUTY_CODE_ZERO;
      else
         status.p = DUTY_CODE_UNK;

      w_chk  = status.m ^ status.d ^ status.p;
      chk_hi = hex_ascii(w_chk[7:4]);
      chk_lo = hex_ascii(w_chk[3:0]);
   end

endmodule : status_encode
`default_nettype wire

// File: rtl/status_reporter.sv
`default_nettype none
// ============================================================================
// Module      : status_reporter
// Description : Sends a 7-byte ASCII status packet ($ M D P C1 C0 LF) to a
//               byte UART, periodically and whenever the status changes.
// Revision    : 1.0 - initial release
// ============================================================================
module status_reporter
   import status_reporter_pkg::*;
#(
   parameter int unsigned REPORT_PERIOD = 50000000,
   parameter bit          CHANGE_REPORT = 1'b1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  mode,
   input  logic        stright,
   input  logic        left,
   input  logic        right,
   input  logic [31:0] duty,
   input  logic        tx_busy,
   output logic [7:0]  dataout,
   output logic        wrsig,
   output logic        pkt_active
);

   localparam int            CW          = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
   localparam logic [CW-1:0] PERIOD_LAST = CW'(REPORT_PERIOD - 1);

   state_t        r_state;
   logic [CW-1:0] r_count;
   logic          r_pending;
   logic [2:0]    r_idx;
   logic [1:0]    r_tmo;
   status_t       r_snap;
   logic [7:0]    r_snap_hi;
   logic [7:0]    r_snap_lo;
   status_t       r_last_sent;

   status_t       w_live;
   logic [7:0]    w_live_hi;
   logic [7:0]    w_live_lo;
   logic          w_period_wrap;
   logic          w_change_req;
   logic [7:0]    w_byte;

   status_encode u_encode (
      .mode    (mode),
      .stright (stright),
      .left    (left),
      .right   (right),
      .duty    (duty),
      .status  (w_live),
      .chk_hi  (w_live_hi),
      .chk_lo  (w_live_lo)
   );

   assign w_period_wrap = (r_count == PERIOD_LAST);
   assign w_change_req  = CHANGE_REPORT && (w_live != r_last_sent);

   // Free-running report period counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (w_period_wrap)
         r_count <= '0;
      else
         r_count <= r_count + CW'(1);
   end

   // Byte selection from the packet snapshot
   always_comb begin
      case (r_idx)
         3'd0:    w_byte = BYTE_START;
         3'd1:    w_byte = r_snap.m;
         3'd2:    w_byte = r_snap.d;
         3'd3:    w_byte = r_snap.p;
         3'd4:    w_byte = r_snap_hi;
         3'd5:    w_byte = r_snap_lo;
         default: w_byte = BYTE_LF;
      endcase
   end

   // Packet sequencer; a change request is a live comparison, so any number
   // of changes during a packet collapse into one follow-up packet
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         wrsig       <= 1'b0;
         dataout     <= 8'h00;
         pkt_active  <= 1'b0;
         r_idx       <= 3'd0;
         r_tmo       <= 2'd0;
         r_pending   <= 1'b0;
         r_snap      <= '0;
         r_snap_hi   <= 8'h00;
         r_snap_lo   <= 8'h00;
         r_last_sent <= {8'hFF, 8'hFF, 8'hFF};
      end else begin
         if (w_period_wrap)
            r_pending <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (r_pending || w_change_req)
                  r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               r_snap     <= w_live;
               r_snap_hi  <= w_live_hi;
               r_snap_lo  <= w_live_lo;
               r_pending  <= w_period_wrap;
               r_idx      <= 3'd0;
               pkt_active <= 1'b1;
               r_state    <= ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
               if (!tx_busy) begin
                  wrsig   <= 1'b1;
                  dataout <= w_byte;
                  r_state <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               wrsig   <= 1'b0;
               r_tmo   <= 2'd0;
               r_state <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               // A UART that never raises busy is assumed to have taken the byte
               if (tx_busy || (r_tmo == 2'd3))
                  r_state <= ST_WAIT_DONE;
               else
                  r_tmo <= r_tmo + 2'd1;
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  if (r_idx == LAST_IDX) begin
                     r_last_sent <= r_snap;
                     pkt_active  <= 1'b0;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_state <= ST_WAIT_RDY;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule : status_reporter
`default_nettype wire

// File: doc/status_reporter.md
STATUS_REPORTER -- requirements
Module: status_reporter

Interface
REQ-001 Parameter REPORT_PERIOD, default 50000000, is the clock cycles between periodic reports (1 s at 50 MHz).
REQ-002 Parameter CHANGE_REPORT, default 1, enables an extra report whenever the reported status changes.
REQ-003 Port clk  input  1  single system clock; all logic is on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port mode  input  2  current control mode (0..3) from the command decoder.
REQ-006 Port stright, left, right  input  1 each  current steering outputs.
REQ-007 Port duty  input  32  current PWM duty word.
REQ-008 Port tx_busy  input  1  UART transmitter busy; high while a byte is being serialised.
REQ-009 Port dataout  output  8  byte presented to the UART transmitter.
REQ-010 Port wrsig  output  1  single-cycle byte write strobe to the UART transmitter.
REQ-011 Port pkt_active  output  1  high from packet start until the last byte completes.

Function
REQ-012 Each packet SHALL be 7 bytes: 0x24 '$', M, D, P, C1, C0, 0x0A.
REQ-013 M SHALL be ASCII '0'+mode (0x30..0x33).
REQ-014 D SHALL be 'W' (0x57) for stright-only, 'A' (0x41) for left-only, 'D' (0x44) for right-only, 'S' (0x53) for all zero, and 'X' (0x58) for any other combination.
REQ-015 P SHALL be 'H' (0x48) for duty 1288490188, 'L' (0x4C) for 2791728742, 'N' (0x4E) for 2147483648, '0' (0x30) for 0, and '?' (0x3F) otherwise.
REQ-016 C1 and C0 SHALL be the uppercase ASCII hex digits (high nibble first) of M XOR D XOR P.
REQ-017 M, D and P SHALL be computed from a snapshot of the inputs taken in the cycle the packet starts; input changes during a packet SHALL NOT alter the bytes in flight.
REQ-018 A free-running period counter SHALL count 0..REPORT_PERIOD-1, wrap to 0, and raise a periodic request on wrap.
REQ-019 When CHANGE_REPORT=1, any difference between the live {M,D,P} and the last sent {M,D,P} SHALL raise a change request.
REQ-020 Pending requests SHALL be held while a packet is active; periodic and change requests arriving together or during a packet SHALL merge into exactly one subsequent packet.
REQ-021 FSM states SHALL be IDLE, LOAD, WAIT_RDY, STROBE, WAIT_BUSY, WAIT_DONE.
REQ-022 IDLE->LOAD when a request is pending.
REQ-023 LOAD: capture the snapshot, clear pending, set byte index 0, set pkt_active=1, then go to WAIT_RDY.
REQ-024 WAIT_RDY->STROBE when tx_busy=0.
REQ-025 STROBE: wrsig=1 for exactly one cycle with dataout holding byte[index], then go to WAIT_BUSY.
REQ-026 WAIT_BUSY->WAIT_DONE on tx_busy=1.
REQ-027 If tx_busy stays low for 4 cycles in WAIT_BUSY, the byte SHALL be treated as accepted and the FSM SHALL go to WAIT_DONE.
REQ-028 WAIT_DONE, on tx_busy=0: advance the index and go to WAIT_RDY; after index 6, update last-sent {M,D,P}, clear pkt_active and go to IDLE.
REQ-029 dataout SHALL remain stable from STROBE until the next STROBE.
REQ-030 wrsig SHALL never be asserted while tx_busy=1.

Reset
REQ-031 On rst_n low, asynchronously: FSM=IDLE, wrsig=0, dataout=0x00, pkt_active=0, period counter=0, index=0.
REQ-032 On rst_n low, last-sent {M,D,P} SHALL be set to 0xFF each so that the first packet is forced after reset.
REQ-033 Reset mid-packet SHALL abort the packet immediately; no further wrsig SHALL follow until a new request arrives.

Structure
REQ-034 Packet byte constants ('$', LF, direction and duty codes) and the three duty words SHALL live in a shared package, for reuse by the command decoder.
REQ-035 A combinational sub-module status_encode SHALL map {mode, steering, duty} to {M,D,P,checksum hex}.

Verification
REQ-036 Release reset with mode=0, all steering 0, duty=0 and tx_busy modelled at 10 cycles per byte -> bytes 24 30 53 30 35 33 0A.
REQ-037 Set mode=1, stright=1, duty=1288490188 -> change packet 24 31 57 48 32 45 0A.
REQ-038 Change duty to 2791728742 during byte 2 of a packet -> in-flight packet unchanged, then exactly one packet with P=0x4C.
REQ-039 Hold inputs constant with REPORT_PERIOD=1000 -> identical packets start 1000 cycles apart, with no change packets.
REQ-040 tx_busy held high for 500 cycles -> no wrsig during that time; packet resumes intact.
REQ-041 Assert rst_n low at byte 4 -> wrsig stops immediately; after release the reset packet of REQ-036 is sent.
